// File: rtl/mem_bus_dma.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_dma
//  Purpose  : Word-granular copy / fill engine mastering a picorv32-native
//             memory bus (valid/ready, 32-bit addr/data, 4-bit wstrb).
//             Every bus transaction is followed by at least one idle cycle
//             so a byte-serial responder can re-arm between accesses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    // command interface
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_fill_mode,
    input  logic [31:0]          cmd_src,
    input  logic [31:0]          cmd_dst,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [31:0]          cmd_fill_data,
    input  logic                 abort,
    // memory bus
    output logic                 mem_valid,
    output logic                 mem_instr,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    // status
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [LEN_WIDTH-1:0] words_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR_REQ = 3'd3,
        S_WR_GAP = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_MISALGN = 2'b01;
    localparam logic [1:0] ST_ABORTED = 2'b10;

    state_t                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic                   fill_mode_q, fill_mode_d;
    logic [31:0]            fill_q, fill_d;
    logic [31:0]            data_q, data_d;
    logic                   mem_valid_q, mem_valid_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic                   busy_q, busy_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   done_q, done_d;
    logic [1:0]             status_q, status_d;
    logic [LEN_WIDTH-1:0]   words_done_q, words_done_d;

    // State and all registered outputs; reset drops mem_valid immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            fill_mode_q  <= 1'b0;
            fill_q       <= '0;
            data_q       <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            status_q     <= ST_OK;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            fill_mode_q  <= fill_mode_d;
            fill_q       <= fill_d;
            data_q       <= data_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            status_q     <= status_d;
            words_done_q <= words_done_d;
        end
    end

    // Next-state logic; bus requests are set up one cycle ahead so that the
    // bus outputs come straight from flops and stay frozen while waiting
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        fill_mode_d  = fill_mode_q;
        fill_d       = fill_q;
        data_d       = data_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        busy_d       = busy_q;
        cmd_ready_d  = cmd_ready_q;
        done_d       = 1'b0;
        status_d     = status_q;
        words_done_d = words_done_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    src_d        = cmd_src;
                    dst_d        = cmd_dst;
                    rem_d        = cmd_len;
                    fill_mode_d  = cmd_fill_mode;
                    fill_d       = cmd_fill_data;
                    words_done_d = '0;
                    status_d     = ST_OK;
                    busy_d       = 1'b1;
                    cmd_ready_d  = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if ((cmd_dst[1:0] != 2'b00) ||
                                 (!cmd_fill_mode && (cmd_src[1:0] != 2'b00))) begin
                        status_d = ST_MISALGN;
                        state_d  = S_FIN;
                        done_d   = 1'b1;
                    end else if (cmd_fill_mode) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = cmd_dst;
                        mem_wdata_d = cmd_fill_data;
                        mem_wstrb_d = 4'hF;
                        state_d     = S_WR_REQ;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = cmd_src;
                        mem_wstrb_d = 4'h0;
                        state_d     = S_RD_REQ;
                    end
                end
            end

            S_RD_REQ: begin
                if (mem_valid_q && mem_ready) begin
                    data_d      = mem_rdata;
                    mem_valid_d = 1'b0;
                    state_d     = S_RD_GAP;
                end
            end

            S_RD_GAP: begin
                mem_valid_d = 1'b1;
                mem_addr_d  = dst_q;
                mem_wdata_d = data_q;
                mem_wstrb_d = 4'hF;
                state_d     = S_WR_REQ;
            end

            S_WR_REQ: begin
                if (mem_valid_q && mem_ready) begin
                    mem_valid_d  = 1'b0;
                    words_done_d = words_done_q + LEN_WIDTH'(1);
                    rem_d        = rem_q - LEN_WIDTH'(1);
                    src_d        = src_q + 32'd4;
                    dst_d        = dst_q + 32'd4;
                    state_d      = S_WR_GAP;
                end
            end

            S_WR_GAP: begin
                // Finishing the count takes priority over a pending abort
                if (rem_q == '0) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else if (abort) begin
                    status_d = ST_ABORTED;
                    state_d  = S_FIN;
                    done_d   = 1'b1;
                end else if (fill_mode_q) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = dst_q;
                    mem_wdata_d = fill_q;
                    mem_wstrb_d = 4'hF;
                    state_d     = S_WR_REQ;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = src_q;
                    mem_wstrb_d = 4'h0;
                    state_d     = S_RD_REQ;
                end
            end

            S_FIN: begin
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready  = cmd_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_instr  = 1'b0;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign words_done = words_done_q;

endmodule
`default_nettype wire

// File: doc/mem_bus_dma.md
Name: mem_bus_dma

Overview:
- Bus initiator on the picorv32-native memory interface (valid/ready, 32-bit addr/wdata/rdata, 4-bit wstrb).
- Performs word-granular copy (memory to memory) or fill (constant to memory) commands.
- Used to clear or blit the frame buffer region without CPU involvement.
- Sits in front of a byte-serial memory responder, through an arbiter shared with the CPU. Drives the bus the same way picorv32 does.

Parameters:
- LEN_WIDTH, 16: width of the word-count field; max transfer is 2^LEN_WIDTH-1 words.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when IDLE; command accepted on cmd_valid&&cmd_ready
- cmd_fill_mode  in  1  0 = copy, 1 = fill
- cmd_src  in  32  source byte address (copy only)
- cmd_dst  in  32  destination byte address
- cmd_len  in  LEN_WIDTH  number of 32-bit words
- cmd_fill_data  in  32  fill word
- abort  in  1  level; stop at next transaction boundary
- mem_valid  out  1  bus request
- mem_instr  out  1  constant 0
- mem_addr  out  32  word-aligned bus address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  0000 = read, 1111 = write
- mem_ready  in  1  responder completion strobe
- mem_rdata  in  32  read data, valid when mem_ready=1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at command completion
- status  out  2  00 ok, 01 misaligned, 10 aborted; held until next accept
- words_done  out  LEN_WIDTH  words written by the current/last command

Behaviour:
- Reset (async assert, sync release) sets mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, status=00, words_done=0, cmd_ready=1, state=IDLE.
- Reset mid-transaction drops mem_valid immediately. No completion is reported.
- All bus outputs are registered.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN.
- IDLE:
  - On accept, latch src, dst, remaining = cmd_len, mode and fill word.
  - Clear words_done and status.
  - If cmd_len==0: go to FIN, no bus traffic.
  - If dst[1:0]!=0, or (copy and src[1:0]!=0): status=01, go to FIN, no bus traffic.
  - Otherwise go to RD_REQ (copy) or WR_REQ (fill).
  - mem_valid rises the cycle after accept.
- RD_REQ: mem_valid=1, mem_addr=src, mem_wstrb=0000. On mem_ready, capture mem_rdata into the data register, drop mem_valid, and go to RD_GAP.
- RD_GAP: one cycle with mem_valid=0, then go to WR_REQ.
- WR_REQ:
  - mem_valid=1, mem_addr=dst, mem_wstrb=1111, mem_wdata = captured word (copy) or fill word (fill).
  - On mem_ready: drop mem_valid, increment words_done, decrement remaining, add 4 to src and dst (32-bit modulo, wraps at 0xFFFFFFFC to 0). Go to WR_GAP.
- WR_GAP: mem_valid=0 for one cycle.
  - If remaining==0, go to FIN.
  - Else if abort=1, set status=10 and go to FIN.
  - Else go to RD_REQ (copy) or WR_REQ (fill).
- FIN: done=1 for exactly one cycle, busy=0 next cycle, go to IDLE. cmd_ready=1 again the cycle after done.
- Handshake rules:
  - Once mem_valid rises, addr, wdata and wstrb are stable until the cycle mem_ready is sampled high.
  - mem_valid never drops without mem_ready.
  - Between transactions mem_valid is low for at least one cycle (required by the byte-serial responder to re-arm its cycle counter).
  - mem_ready while mem_valid=0 is ignored.
  - mem_ready asserted in the first valid cycle is legal (single-cycle transaction).
- abort is sampled only in the GAP states. An abort raised during RD_REQ lets that word's write complete. An abort during IDLE has no effect.
- cmd_valid while busy is not accepted (cmd_ready=0). The held command is accepted after return to IDLE.
- Word copy/fill time = (responder latency + 1) per bus transaction. Copy needs 2 transactions per word.

Test Plan:
- Fill, dst=0x41000, len=4, data=0xA5A5A5A5, responder ready after 7 cycles -> 4 writes to 0x41000/4/8/C with wstrb 1111; mem_valid low for ≥1 cycle between writes; done pulse once; words_done=4, status=00.
- Copy, src=0x100, dst=0x41000, len=3, memory preloaded 0x11223344/0x55667788/0x99AABBCC -> alternating read/write sequence with wstrb 0000/1111; destination holds the same three words; mem_instr always 0.
- len=0, and separately dst=0x41002 -> no mem_valid ever; done next-but-one cycle; status=00 and 01 respectively.
- Random ready latency 1-10, including ready in the first valid cycle, plus spurious mem_ready while idle -> addr, wdata and wstrb never change while valid; no extra or missing transactions; words_done is exact.
- Copy len=8, abort raised during the 3rd read -> 3 words written, status=10, done pulses, no 4th read issued.
- Fill len=5 with dst=0xFFFFFFF8 -> writes to FFFFFFF8, FFFFFFFC, 0, 4, 8. Separately, assert resetn low mid-WR_REQ -> mem_valid=0 immediately; all outputs at reset values; a new command afterwards runs correctly.
